// File: rtl/kanade_mem_pkg.sv
// Shared encodings for the kanade32 memory access unit.
package kanade_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } mau_state_e;

    // Size 11, odd halfword and unaligned word requests never reach the RAM.
    function automatic logic req_is_err(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'b11) ||
               ((size == SZ_HALF) && off[0]) ||
               ((size == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mau_lane.sv
// Lane extraction, sign/zero extension and sub-word store merge for one
// 32-bit RAM word. Purely combinational.
module mau_lane
    import kanade_mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] mask;

    // Bit position of the addressed lane inside the word.
    always_comb begin
        shamt = 5'd0;
        if (size == SZ_BYTE) begin
            if (BIG_ENDIAN) shamt = {~offset, 3'b000};
            else            shamt = {offset, 3'b000};
        end else if (size == SZ_HALF) begin
            if (BIG_ENDIAN) shamt = {~offset[1], 4'b0000};
            else            shamt = {offset[1], 4'b0000};
        end
    end

    assign shifted = word >> shamt;

    // Right-justify the lane and extend it to 32 bits.
    always_comb begin
        rdata = shifted;
        if (size == SZ_BYTE)
            rdata = sgn ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
        else if (size == SZ_HALF)
            rdata = sgn ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
    end

    // Replace only the addressed lane; every other bit keeps the RAM value.
    always_comb begin
        mask = 32'hFFFF_FFFF;
        if (size == SZ_BYTE)      mask = 32'h0000_00FF << shamt;
        else if (size == SZ_HALF) mask = 32'h0000_FFFF << shamt;
        merged = (word & ~mask) | ((wdata << shamt) & mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store initiator for the word-only kanade32 RAM port.
// Sub-word stores are read-modify-write; illegal requests skip the RAM.
//
// state | meaning
// IDLE  | ready for a request, ram_address held
// READ  | ram_address presented, RAM registering it
// MERGE | ram_q valid: extract load data or build merged store word
// WRITE | ram_wren high for this single cycle
// RESP  | resp_valid pulse, back to IDLE next
module mem_access_unit
    import kanade_mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [29:0] ram_address,
    output logic        ram_wren,
    output logic [31:0] ram_data,
    input  logic [31:0] ram_q
);

    localparam logic [2:0] ST_IDLE  = 3'(IDLE);
    localparam logic [2:0] ST_READ  = 3'(READ);
    localparam logic [2:0] ST_MERGE = 3'(MERGE);
    localparam logic [2:0] ST_WRITE = 3'(WRITE);
    localparam logic [2:0] ST_RESP  = 3'(RESP);

    logic [2:0]  state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        req_err;
    logic [31:0] lane_rdata;
    logic [31:0] lane_merged;

    assign req_err    = req_is_err(req_size, req_addr[1:0]);
    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    // Combinational from state so a reset sampled during WRITE still lets
    // that edge's write land in the RAM.
    assign ram_wren   = (state == ST_WRITE);

    mau_lane #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane (
        .word   (ram_q),
        .offset (off_q),
        .size   (size_q),
        .sgn    (signed_q),
        .wdata  (wdata_q),
        .rdata  (lane_rdata),
        .merged (lane_merged)
    );

    // Sequencer and all request/response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            signed_q    <= 1'b0;
            off_q       <= 2'b00;
            wdata_q     <= 32'h0;
            resp_rdata  <= 32'h0;
            resp_err    <= 1'b0;
            ram_address <= 30'h0;
            ram_data    <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        size_q     <= req_size;
                        signed_q   <= req_signed;
                        off_q      <= req_addr[1:0];
                        wdata_q    <= req_wdata;
                        resp_rdata <= 32'h0;
                        resp_err   <= req_err;
                        if (req_err) begin
                            state <= ST_RESP;
                        end else begin
                            ram_address <= req_addr[31:2];
                            if (req_we && (req_size == SZ_WORD)) begin
                                ram_data <= req_wdata;
                                state    <= ST_WRITE;
                            end else begin
                                state <= ST_READ;
                            end
                        end
                    end
                end
                ST_READ: state <= ST_MERGE;
                ST_MERGE: begin
                    if (we_q) begin
                        ram_data <= lane_merged;
                        state    <= ST_WRITE;
                    end else begin
                        resp_rdata <= lane_rdata;
                        state      <= ST_RESP;
                    end
                end
                ST_WRITE: state <= ST_RESP;
                ST_RESP:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-level memory model.
module tb_mem_access_unit;

    localparam bit BE = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [29:0] ram_address;
    logic        ram_wren;
    logic [31:0] ram_data;
    logic [31:0] ram_q;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic        bd_we;
    logic [7:0]  bd_idx;
    logic [31:0] bd_data;
    logic [29:0] exp_addr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.BIG_ENDIAN(BE)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .ram_address (ram_address),
        .ram_wren    (ram_wren),
        .ram_data    (ram_data),
        .ram_q       (ram_q)
    );

    // RAM with registered address; backdoor port for preloading.
    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        else if (ram_wren) mem[ram_address[7:0]] <= ram_data;
        ram_q <= mem[ram_address[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = 8'(idx); bd_data = val;
        @(posedge clk);
        #1 bd_we = 1'b0;
        ref_mem[idx] = val;
    endtask

    function automatic logic [7:0] get_byte(input logic [31:0] w, input int k);
        logic [31:0] t;
        t = BE ? (w >> (8 * (3 - k))) : (w >> (8 * k));
        return t[7:0];
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input int k, input logic [7:0] b);
        logic [7:0] bs [4];
        for (int i = 0; i < 4; i++) bs[i] = get_byte(w, i);
        bs[k] = b;
        return BE ? {bs[0], bs[1], bs[2], bs[3]} : {bs[3], bs[2], bs[1], bs[0]};
    endfunction

    function automatic logic model_err(input logic [1:0] sz, input logic [1:0] off);
        return (sz == 2'd3) || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input int k,
                                               input logic [1:0] sz, input logic sg);
        logic [7:0]  b;
        logic [15:0] h;
        if (sz == 2'd0) begin
            b = get_byte(w, k);
            return sg ? {{24{b[7]}}, b} : {24'h0, b};
        end else if (sz == 2'd1) begin
            h = BE ? {get_byte(w, k), get_byte(w, k + 1)} : {get_byte(w, k + 1), get_byte(w, k)};
            return sg ? {{16{h[15]}}, h} : {16'h0, h};
        end
        return w;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input int k,
                                                input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        if (sz == 2'd0) return put_byte(w, k, wd[7:0]);
        if (sz == 2'd1) begin
            r = put_byte(w, k, BE ? wd[15:8] : wd[7:0]);
            return put_byte(r, k + 1, BE ? wd[7:0] : wd[15:8]);
        end
        return wd;
    endfunction

    task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
        int          idx, k, exp_lat, exp_wr, cyc, wrs;
        logic        e, got;
        logic [31:0] exp_r, exp_w;
        idx   = int'(a[9:2]);
        k     = int'(a[1:0]);
        e     = model_err(sz, a[1:0]);
        exp_r = 32'h0;
        exp_w = 32'h0;
        if (e) begin
            exp_lat = 1; exp_wr = 0;
        end else if (we) begin
            exp_wr  = 1;
            exp_w   = model_store(ref_mem[idx], k, sz, wd);
            exp_lat = (sz == 2'd2) ? 2 : 4;
        end else begin
            exp_wr  = 0;
            exp_lat = 3;
            exp_r   = model_load(ref_mem[idx], k, sz, sg);
        end
        if (!e) exp_addr = a[31:2];

        @(negedge clk);
        chk("ready_before", {31'h0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;

        cyc = 0; wrs = 0; got = 1'b0;
        while (!got && cyc < 12) begin
            @(negedge clk);
            cyc++;
            chk("busy_ready", {31'h0, req_ready}, 32'd0);
            if (ram_wren) begin
                wrs++;
                chk("wr_cycle", cyc, exp_lat - 1);
                chk("wr_addr", {2'b0, ram_address}, {2'b0, exp_addr});
                chk("wr_data", ram_data, exp_w);
            end
            if (resp_valid) begin
                got = 1'b1;
                chk("rdata", resp_rdata, exp_r);
                chk("err", {31'h0, resp_err}, {31'h0, e});
                chk("ram_addr_hold", {2'b0, ram_address}, {2'b0, exp_addr});
            end
        end
        chk("resp_seen", {31'h0, got}, 32'd1);
        chk("latency", cyc, exp_lat);
        chk("wren_count", wrs, exp_wr);
        if (exp_wr != 0) ref_mem[idx] = exp_w;
        @(negedge clk);
        chk("resp_pulse", {31'h0, resp_valid}, 32'd0);
        chk("ready_after", {31'h0, req_ready}, 32'd1);
        chk("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        logic [31:0] saved, a;
        logic [1:0]  sz;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        bd_we = 1'b0; bd_idx = 8'h0; bd_data = 32'h0;
        exp_addr = 30'h0;
        for (int i = 0; i < 256; i++) poke(i, $urandom);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_wren", {31'h0, ram_wren}, 32'd0);
        chk("rst_ram_addr", {2'b0, ram_address}, 32'h0);
        chk("rst_ram_data", ram_data, 32'h0);

        poke(0, 32'h2008_0005);
        xact(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        poke(64, 32'h12F4_5678);
        xact(1'b0, 2'd0, 1'b1, 32'h101, 32'h0);
        xact(1'b0, 2'd0, 1'b0, 32'h101, 32'h0);
        xact(1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
        xact(1'b0, 2'd1, 1'b1, 32'h100, 32'h0);
        poke(64, 32'h1122_3344);
        xact(1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_00AB);
        chk("byte_store_word", ref_mem[64], 32'h1122_33AB);
        xact(1'b0, 2'd2, 1'b0, 32'h42, 32'h0);
        xact(1'b0, 2'd3, 1'b0, 32'h80, 32'h0);
        xact(1'b1, 2'd1, 1'b0, 32'h81, 32'hFFFF_FFFF);
        xact(1'b1, 2'd2, 1'b0, 32'h3FC, 32'hCAFE_F00D);
        xact(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_BEEF);

        // Reset sampled in MERGE of a half store: the transaction must vanish.
        saved = ref_mem[64];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0;
        req_addr = 32'h100; req_wdata = 32'h0000_5A5A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_wren", {31'h0, ram_wren}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_addr = 30'h0;
        @(negedge clk);
        chk("mid_rst_ready", {31'h0, req_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("mid_rst_no_wren", {31'h0, ram_wren}, 32'd0);
            chk("mid_rst_no_resp", {31'h0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        chk("mid_rst_mem", mem[64], saved);
        chk("mid_rst_addr", {2'b0, ram_address}, 32'h0);

        for (int n = 0; n < 200; n++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            xact(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
